// File: rtl/main_fsm.sv
// Moore main controller for the multicycle ARM datapath: fetch/decode/execute/memory/writeback.
// Optional memory handshake stalls (MemReady) enabled by defining MAIN_FSM_MEM_WAIT_EN.
module main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
`ifdef MAIN_FSM_MEM_WAIT_EN
    input  logic       MemReady,
`endif
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_UNKNOWN = 4'd10
    } state_t;

    state_t r_state;
    logic   w_ready;

`ifdef MAIN_FSM_MEM_WAIT_EN
    assign w_ready = MemReady;
`else
    assign w_ready = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:   if (w_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (Op)
                        2'b00:   r_state <= Funct[5] ? S_EXECI : S_EXECR;
                        2'b01:   r_state <= S_MEMADR;
                        2'b10:   r_state <= S_BRANCH;
                        default: r_state <= S_UNKNOWN;
                    endcase
                end
                S_MEMADR:  r_state <= Funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:   if (w_ready) r_state <= S_MEMWB;
                S_MEMWR:   if (w_ready) r_state <= S_FETCH;
                S_EXECR,
                S_EXECI:   r_state <= S_ALUWB;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    // Outputs decode from State only; the FETCH strobes additionally wait on the handshake.
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        Illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                IRWrite   = w_ready;
                NextPC    = w_ready;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR:  ALUSrcB = 2'b01;
            S_MEMRD:   AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_EXECR:   ALUOp = 1'b1;
            S_EXECI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            S_ALUWB:   RegW = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
            end
            S_UNKNOWN: Illegal = 1'b1;
            default: ;
        endcase
    end

    assign State = r_state;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: per-cycle vector table plus reset and handshake sequences.
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite, AdrSrc, ALUOp, NextPC, RegW, MemW, Branch, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] State;
`ifdef MAIN_FSM_MEM_WAIT_EN
    logic       MemReady;
`endif

    always #5 clk = ~clk;

    main_fsm dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
`ifdef MAIN_FSM_MEM_WAIT_EN
        .MemReady(MemReady),
`endif
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUOp(ALUOp), .NextPC(NextPC), .RegW(RegW),
        .MemW(MemW), .Branch(Branch), .Illegal(Illegal), .State(State)
    );

    // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,NextPC,RegW,MemW,Branch,Illegal}
    logic [13:0] w_outs;
    assign w_outs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                     ALUOp, NextPC, RegW, MemW, Branch, Illegal};

    localparam logic [13:0] R_FETCH   = 14'b1_0_01_10_10_0_1_0_0_0_0;
    localparam logic [13:0] R_DECODE  = 14'b0_0_01_10_10_0_0_0_0_0_0;
    localparam logic [13:0] R_MEMADR  = 14'b0_0_00_01_00_0_0_0_0_0_0;
    localparam logic [13:0] R_MEMRD   = 14'b0_1_00_00_00_0_0_0_0_0_0;
    localparam logic [13:0] R_MEMWB   = 14'b0_0_00_00_01_0_0_1_0_0_0;
    localparam logic [13:0] R_MEMWR   = 14'b0_1_00_00_00_0_0_0_1_0_0;
    localparam logic [13:0] R_EXECR   = 14'b0_0_00_00_00_1_0_0_0_0_0;
    localparam logic [13:0] R_EXECI   = 14'b0_0_00_01_00_1_0_0_0_0_0;
    localparam logic [13:0] R_ALUWB   = 14'b0_0_00_00_00_0_0_1_0_0_0;
    localparam logic [13:0] R_BRANCH  = 14'b0_0_00_01_10_0_0_0_0_1_0;
    localparam logic [13:0] R_UNKNOWN = 14'b0_0_00_00_00_0_0_0_0_0_1;

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  st;
        logic [13:0] outs;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Inputs are applied before the edge; expectations are the state after it.
        // Garbage Op/Funct (11/111111) outside DECODE/MEMADR must be ignored.
        tbl[0]  = '{2'b11, 6'h3f,      4'd1,  R_DECODE};
        tbl[1]  = '{2'b00, 6'b001000,  4'd6,  R_EXECR};
        tbl[2]  = '{2'b11, 6'h3f,      4'd8,  R_ALUWB};
        tbl[3]  = '{2'b11, 6'h3f,      4'd0,  R_FETCH};
        tbl[4]  = '{2'b11, 6'h3f,      4'd1,  R_DECODE};
        tbl[5]  = '{2'b01, 6'b011001,  4'd2,  R_MEMADR};
        tbl[6]  = '{2'b01, 6'b011001,  4'd3,  R_MEMRD};
        tbl[7]  = '{2'b10, 6'h00,      4'd4,  R_MEMWB};
        tbl[8]  = '{2'b11, 6'h00,      4'd0,  R_FETCH};
        tbl[9]  = '{2'b11, 6'h3f,      4'd1,  R_DECODE};
        tbl[10] = '{2'b01, 6'b011000,  4'd2,  R_MEMADR};
        tbl[11] = '{2'b01, 6'b011000,  4'd5,  R_MEMWR};
        tbl[12] = '{2'b11, 6'h3f,      4'd0,  R_FETCH};
        tbl[13] = '{2'b11, 6'h3f,      4'd1,  R_DECODE};
        tbl[14] = '{2'b10, 6'h00,      4'd9,  R_BRANCH};
        tbl[15] = '{2'b11, 6'h3f,      4'd0,  R_FETCH};
        tbl[16] = '{2'b00, 6'h00,      4'd1,  R_DECODE};
        tbl[17] = '{2'b11, 6'h00,      4'd10, R_UNKNOWN};
        tbl[18] = '{2'b01, 6'h3f,      4'd0,  R_FETCH};
        tbl[19] = '{2'b01, 6'h3f,      4'd1,  R_DECODE};
        tbl[20] = '{2'b00, 6'b100000,  4'd7,  R_EXECI};
        tbl[21] = '{2'b01, 6'h3f,      4'd8,  R_ALUWB};
        tbl[22] = '{2'b11, 6'h3f,      4'd0,  R_FETCH};

        reset = 1'b0;
        Op    = 2'b00;
        Funct = 6'h00;
`ifdef MAIN_FSM_MEM_WAIT_EN
        MemReady = 1'b1;
`endif
        #3;
        chk("reset_state", 32'(State), 32'd0);
        chk("reset_outs", 32'(w_outs), 32'(R_FETCH));
        step();
        chk("reset_hold_state", 32'(State), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            Op    = tbl[i].op;
            Funct = tbl[i].funct;
            step();
            chk($sformatf("vec%0d_state", i), 32'(State), 32'(tbl[i].st));
            chk($sformatf("vec%0d_outs", i), 32'(w_outs), 32'(tbl[i].outs));
        end

        // Reset in the middle of a data-processing instruction.
        Op = 2'b00; Funct = 6'h00;
        step();
        step();
        chk("pre_reset_execr", 32'(State), 32'd6);
        #2 reset = 1'b0;
        #1;
        chk("midreset_state", 32'(State), 32'd0);
        chk("midreset_irwrite", 32'(IRWrite), 32'd1);
        chk("midreset_regw", 32'(RegW), 32'd0);
        step();
        chk("midreset_hold", 32'(State), 32'd0);
        chk("midreset_no_regw", 32'(RegW), 32'd0);
        reset = 1'b1;
        step();
        chk("release_decode", 32'(State), 32'd1);
        Op = 2'b10;
        step();
        step();
        chk("back_to_fetch", 32'(State), 32'd0);

`ifdef MAIN_FSM_MEM_WAIT_EN
        // Fetch stalled three cycles, then advances on the ready cycle.
        for (int i = 0; i < 3; i++) begin
            MemReady = 1'b0;
            #1;
            chk($sformatf("fwait%0d_irwrite", i), 32'(IRWrite), 32'd0);
            chk($sformatf("fwait%0d_nextpc", i), 32'(NextPC), 32'd0);
            chk($sformatf("fwait%0d_srcb", i), 32'(ALUSrcB), 32'd2);
            step();
            chk($sformatf("fwait%0d_state", i), 32'(State), 32'd0);
        end
        MemReady = 1'b1;
        #1;
        chk("fready_irwrite", 32'(IRWrite), 32'd1);
        chk("fready_nextpc", 32'(NextPC), 32'd1);
        step();
        chk("fready_decode", 32'(State), 32'd1);
        Op = 2'b01; Funct = 6'b011000;
        step();
        step();
        chk("str_memwr", 32'(State), 32'd5);
        begin
            int memw_cycles;
            memw_cycles = 0;
            for (int i = 0; i < 3; i++) begin
                MemReady = (i == 2);
                #1;
                if (MemW === 1'b1 && AdrSrc === 1'b1) memw_cycles++;
                step();
            end
            chk("str_stall_memw_cycles", 32'(memw_cycles), 32'd3);
            chk("str_stall_done", 32'(State), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
